// File: rtl/adpll_pkg.sv
// ============================================================
// adpll_pkg : shared types and constants for the TDC control path
// Revision  : 1.0
// ============================================================
`default_nettype none

package adpll_pkg;

  localparam int TDC_W = 12;
  localparam logic [TDC_W-1:0] TDC_TIMEOUT_CODE = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4
  } tdc_state_t;

endpackage

`default_nettype wire

// File: rtl/tdc_avg_acc.sv
// ============================================================
// tdc_avg_acc : sample accumulator with clear and averaging shift
// Revision    : 1.0
// ============================================================
`default_nettype none

module tdc_avg_acc
  import adpll_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic [TDC_W-1:0] sample,
  output logic [TDC_W-1:0] avg
);

  localparam int ACC_W = TDC_W + AVG_LOG2;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum_next;

  // avg includes the sample being added this cycle so the final result is ready at the last capture
  assign w_sum_next = r_acc + ACC_W'(sample);
  assign avg        = w_sum_next[AVG_LOG2 +: TDC_W];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_acc <= '0;
    end else if (add) begin
      r_acc <= w_sum_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdc_measure_ctrl.sv
// ============================================================
// tdc_measure_ctrl : arms the TDC, waits for done/timeout, hands the delay downstream
// Optional averaging over 2**AVG_LOG2 samples when TDC_AVG_EN is defined.  Revision 1.0
// ============================================================
`default_nettype none

module tdc_measure_ctrl
  import adpll_pkg::*;
#(
  parameter int ARM_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int AVG_LOG2       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tdc_done,
  input  logic [TDC_W-1:0] tdc_delay,
  input  logic             result_ready,
  output logic             tdc_rst,
  output logic             busy,
  output logic             result_valid,
  output logic [TDC_W-1:0] result,
  output logic             timeout_err
);

  localparam logic [3:0]  ARM_LAST = 4'(ARM_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  tdc_state_t       r_state;
  logic [3:0]       r_arm_cnt;
  logic [15:0]      r_wait_cnt;
  logic [TDC_W-1:0] r_sample;
  logic             r_tdc_rst;
  logic             r_result_valid;
  logic [TDC_W-1:0] r_result;
  logic             r_timeout;

  logic             w_last_sample;
  logic [TDC_W-1:0] w_capture_value;

`ifdef TDC_AVG_EN
  localparam int N_SAMPLES = 1 << AVG_LOG2;

  logic [4:0]       r_smp_cnt;
  logic [TDC_W-1:0] w_avg;

  tdc_avg_acc #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state == ST_IDLE && start),
    .add    (r_state == ST_CAPTURE),
    .sample (r_sample),
    .avg    (w_avg)
  );

  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_IDLE && start)) begin
      r_smp_cnt <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_smp_cnt <= r_smp_cnt + 5'd1;
    end
  end

  assign w_last_sample   = (r_smp_cnt == 5'(N_SAMPLES - 1));
  assign w_capture_value = w_avg;
`else
  logic [3:0] cfg_avg_log2_unused;
  assign cfg_avg_log2_unused = 4'(AVG_LOG2);

  assign w_last_sample   = 1'b1;
  assign w_capture_value = r_sample;
`endif

  // reset must hold the TDC in reset immediately, not one edge later
  assign tdc_rst      = r_tdc_rst | reset;
  assign busy         = (r_state != ST_IDLE);
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign timeout_err  = r_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_arm_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_sample       <= '0;
      r_tdc_rst      <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            r_tdc_rst <= 1'b1;
            r_timeout <= 1'b0;
          end
        end
        ST_ARM: begin
          if (r_arm_cnt == ARM_LAST) begin
            r_state    <= ST_WAIT;
            r_tdc_rst  <= 1'b0;
            r_wait_cnt <= '0;
          end else begin
            r_arm_cnt <= r_arm_cnt + 4'd1;
          end
        end
        ST_WAIT: begin
          // done takes priority over a timeout landing in the same cycle
          if (tdc_done) begin
            r_sample <= tdc_delay;
            r_state  <= ST_CAPTURE;
          end else if (r_wait_cnt == TO_LAST) begin
            r_state        <= ST_OUTPUT;
            r_result       <= TDC_TIMEOUT_CODE;
            r_timeout      <= 1'b1;
            r_result_valid <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        ST_CAPTURE: begin
          if (w_last_sample) begin
            r_state        <= ST_OUTPUT;
            r_result       <= w_capture_value;
            r_result_valid <= 1'b1;
          end else begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            r_tdc_rst <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_measure_ctrl.sv
// ============================================================
// tb_tdc_measure_ctrl : directed + randomized bench for tdc_measure_ctrl
// Revision            : 1.0
// ============================================================
`default_nettype none

module tb_tdc_measure_ctrl;
  import adpll_pkg::*;

  localparam int ARM_C = 2;
  localparam int TO_C  = 8;
  localparam int AL    = 2;
`ifdef TDC_AVG_EN
  localparam int N = 1 << AL;
`else
  localparam int N = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             tdc_done = 1'b0;
  logic [TDC_W-1:0] tdc_delay = '0;
  logic             result_ready = 1'b0;
  logic             tdc_rst;
  logic             busy;
  logic             result_valid;
  logic [TDC_W-1:0] result;
  logic             timeout_err;

  tdc_measure_ctrl #(
    .ARM_CYCLES     (ARM_C),
    .TIMEOUT_CYCLES (TO_C),
    .AVG_LOG2       (AL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tdc_done     (tdc_done),
    .tdc_delay    (tdc_delay),
    .result_ready (result_ready),
    .tdc_rst      (tdc_rst),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int               gap_q[$];
  logic [TDC_W-1:0] val_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected result: average of all samples, or the timeout code if any sample timed out.
  function automatic int model_result();
    int sum = 0;
    for (int s = 0; s < N; s++) begin
      if (gap_q[s] < 0) return 32'hFFF;
      sum += int'(val_q[s]);
    end
    return sum / N;
  endfunction

  function automatic bit model_timeout();
    for (int s = 0; s < N; s++) if (gap_q[s] < 0) return 1'b1;
    return 1'b0;
  endfunction

  // One full start..handshake transaction driven cycle by cycle from gap_q/val_q.
  task automatic measure(input int bp, input bit arm_glitch);
    int exp_res;
    bit exp_to;
    bit to_hit = 1'b0;
    exp_res = model_result();
    exp_to  = model_timeout();
    check("idle_rst", tdc_rst, 0);
    result_ready = (bp == 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_clear", timeout_err, 0);
    for (int s = 0; s < N && !to_hit; s++) begin
      for (int a = 0; a < ARM_C; a++) begin
        check("arm_rst", tdc_rst, 1);
        check("arm_busy", busy, 1);
        tdc_done  = arm_glitch && (a == 0);
        tdc_delay = 12'hABC;
        step();
      end
      tdc_done = 1'b0;
      check("wait_rst", tdc_rst, 0);
      if (gap_q[s] < 0) begin
        for (int w = 0; w < TO_C; w++) begin
          check("wait_rv", result_valid, 0);
          step();
        end
        to_hit = 1'b1;
      end else begin
        for (int w = 0; w < gap_q[s]; w++) begin
          check("wait_rv", result_valid, 0);
          step();
        end
        tdc_done  = 1'b1;
        tdc_delay = val_q[s];
        step();
        tdc_done  = 1'b0;
        tdc_delay = 12'($urandom);
        check("capture_rv", result_valid, 0);
        step();
      end
    end
    for (int i = 0; i < bp; i++) begin
      result_ready = 1'b0;
      start = (i == 1);
      check("out_rv", result_valid, 1);
      check("out_result", result, exp_res);
      check("out_busy", busy, 1);
      step();
    end
    start = 1'b0;
    result_ready = 1'b1;
    check("out_rv_final", result_valid, 1);
    check("out_result_final", result, exp_res);
    check("out_timeout", timeout_err, exp_to);
    step();
    check("hs_rv", result_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_timeout", timeout_err, exp_to);
    step();
    check("idle_no_restart", busy, 0);
    check("idle_result_hold", result, exp_res);
    result_ready = 1'b0;
  endtask

  task automatic load_fixed(input int g, input int base);
    gap_q.delete();
    val_q.delete();
    for (int s = 0; s < N; s++) begin
      gap_q.push_back(g);
      val_q.push_back(12'(base + s));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_tdc_rst", tdc_rst, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    check("post_rst_tdc_rst", tdc_rst, 0);
    check("post_rst_rv", result_valid, 0);
    check("post_rst_result", result, 0);
    check("post_rst_timeout", timeout_err, 0);

    // Directed reference transaction
    gap_q.delete();
    val_q.delete();
`ifdef TDC_AVG_EN
    gap_q = '{3, 0, 1, 2};
    val_q = '{12'd100, 12'd101, 12'd102, 12'd104};
`else
    gap_q = '{3};
    val_q = '{12'h05A};
`endif
    measure(0, 1'b0);

    // Timeout on first sample, then a normal run clears the error
    load_fixed(-1, 0);
    measure(2, 1'b0);
    load_fixed(TO_C - 1, 12'h3C0);
    measure(0, 1'b0);

    // Backpressure with a start inside OUTPUT, and a done pulse during ARM
    load_fixed(2, 12'h7F0);
    measure(5, 1'b0);
    load_fixed(1, 12'h210);
    measure(1, 1'b1);

    // Reset mid-measurement discards partial samples
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (ARM_C) step();
    if (N > 1) begin
      tdc_done  = 1'b1;
      tdc_delay = 12'hFF0;
      step();
      tdc_done = 1'b0;
      step();
      repeat (ARM_C) step();
    end
    step();
    reset = 1'b1;
    #1;
    check("midrst_tdc_rst", tdc_rst, 1);
    step();
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_timeout", timeout_err, 0);
    reset = 1'b0;
    step();
    check("midrst_idle_rv", result_valid, 0);
    load_fixed(0, 12'h020);
    measure(0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      gap_q.delete();
      val_q.delete();
      for (int s = 0; s < N; s++) begin
        gap_q.push_back(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO_C - 1)));
        val_q.push_back(12'($urandom));
      end
      measure(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
